overlay_frame_scheduler: RTL and testbench

- Owns all writes into the compositor's 80-entry text RAM and its image/text enables.
- Two requesters submit character writes:
  - requester A: host/UART;
  - requester B: classifier result.
- Writes are round-robin arbitrated into a small FIFO, then committed to the text RAM only during vertical blanking, so no frame shows a half-updated string.
- enable_image and enable_text are shadowed and switch only at frame boundaries.

---
 rtl/overlay_frame_scheduler_if.sv | 28 ++
 rtl/overlay_frame_scheduler.sv | 159 +++++++++++++++
 tb/tb_overlay_frame_scheduler.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/overlay_frame_scheduler_if.sv
// Requester bus for the overlay frame scheduler.
// Two character-write requesters share this interface:
//   a_*  host/UART requester
//   b_*  classifier-result requester
// Each requester has valid/addr/char as outputs and ready as an input.
// master: the requester side; slave: the scheduler side.
interface overlay_frame_scheduler_if #(
    parameter int ADDR_W = 7
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [7:0]        a_char;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [7:0]        b_char;

    modport master (
        output a_valid, a_addr, a_char, b_valid, b_addr, b_char,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_char, b_valid, b_addr, b_char,
        output a_ready, b_ready
    );
endinterface

// File: rtl/overlay_frame_scheduler.sv
// Overlay frame scheduler: sole writer of the compositor text RAM and its
// image/text enables. Two requesters are round-robin arbitrated into a
// small write queue that is committed to the text RAM only during vertical
// blanking. Enables are shadowed and switch only at frame boundaries.
// Ports:
//   pixel_clk, rst          clock, synchronous active-high reset
//   y_coord                 current raster line
//   req (slave)             requester A/B valid/ready/addr/char
//   cfg_valid, cfg_enable_* strobe + pending enable values
//   txt_we/waddr/wdata      registered text RAM write port
//   enable_image/text       frame-aligned enables
//   frame_start             one-cycle pulse after blanking begins
//   err_count               saturating count of dropped out-of-range writes
//   fifo_level              queue occupancy
module overlay_frame_scheduler #(
    parameter int TEXT_DEPTH = 80,
    parameter int FIFO_DEPTH = 8,
    parameter int V_ACTIVE   = 720,
    parameter int ADDR_W     = 7,
    localparam int PW        = $clog2(FIFO_DEPTH),
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     pixel_clk,
    input  logic                     rst,
    input  logic [9:0]               y_coord,
    overlay_frame_scheduler_if.slave req,
    input  logic                     cfg_valid,
    input  logic                     cfg_enable_image,
    input  logic                     cfg_enable_text,
    output logic                     txt_we,
    output logic [ADDR_W-1:0]        txt_waddr,
    output logic [7:0]               txt_wdata,
    output logic                     enable_image,
    output logic                     enable_text,
    output logic                     frame_start,
    output logic [7:0]               err_count,
    output logic [LW-1:0]            fifo_level
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        ch;
    } entry_t;

    typedef enum logic {IDLE, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] TEXT_LIMIT = ADDR_W'(TEXT_DEPTH);
    localparam logic [9:0]        VB_LINE    = 10'(V_ACTIVE);
    localparam logic [LW-1:0]     FULL_LVL   = LW'(FIFO_DEPTH);

    state_t  state, state_nxt;
    entry_t  mem [FIFO_DEPTH];
    entry_t  in_entry, out_entry;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic    vb, vb_q, vb_rise;
    logic    full, empty, push, pop, accept;
    logic    a_rdy, b_rdy;
    logic    prefer_b;  // set when A won the last acceptance
    logic    pend_image, pend_text;

    assign vb      = (y_coord >= VB_LINE);
    assign vb_rise = vb & ~vb_q;
    assign full    = (fifo_level == FULL_LVL);
    assign empty   = (fifo_level == '0);

    // Ready depends only on the level at the start of the cycle, so a full
    // queue stays closed even in the cycle it pops.
    always_comb begin
        a_rdy = 1'b0;
        b_rdy = 1'b0;
        if (!rst && !full) begin
            if (req.a_valid && (!req.b_valid || !prefer_b))
                a_rdy = 1'b1;
            else if (req.b_valid)
                b_rdy = 1'b1;
        end
    end

    assign req.a_ready = a_rdy;
    assign req.b_ready = b_rdy;

    assign accept   = (req.a_valid & a_rdy) | (req.b_valid & b_rdy);
    assign in_entry = b_rdy ? entry_t'{req.b_addr, req.b_char}
                            : entry_t'{req.a_addr, req.a_char};
    // Out-of-range requests are still accepted so they never stall a requester.
    assign push      = accept & (in_entry.addr < TEXT_LIMIT);
    assign pop       = (state == DRAIN) & vb & ~empty;
    assign out_entry = mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vb_rise && !empty) state_nxt = DRAIN;
            DRAIN:   if (!vb || empty)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge pixel_clk) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            vb_q         <= 1'b0;
            frame_start  <= 1'b0;
            prefer_b     <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            err_count    <= '0;
            txt_we       <= 1'b0;
            txt_waddr    <= '0;
            txt_wdata    <= '0;
            pend_image   <= 1'b0;
            pend_text    <= 1'b0;
            enable_image <= 1'b0;
            enable_text  <= 1'b0;
        end else begin
            vb_q        <= vb;
            frame_start <= vb_rise;

            if (accept) prefer_b <= a_rdy;
            if (accept && !push && err_count != 8'hFF)
                err_count <= err_count + 8'd1;

            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase

            // Non-ASCII codes are replaced by '?' so the font ROM never
            // sees an index outside its table.
            txt_we <= pop;
            if (pop) begin
                txt_waddr <= out_entry.addr;
                txt_wdata <= out_entry.ch[7] ? 8'h3F : out_entry.ch;
            end

            // Enables load from the old pending values, so a strobe in the
            // vb_rise cycle lands one frame later.
            if (cfg_valid) begin
                pend_image <= cfg_enable_image;
                pend_text  <= cfg_enable_text;
            end
            if (vb_rise) begin
                enable_image <= pend_image;
                enable_text  <= pend_text;
            end
        end
    end
endmodule

// File: tb/tb_overlay_frame_scheduler.sv
module tb_overlay_frame_scheduler;
    logic       pixel_clk = 1'b0;
    logic       rst;
    logic [9:0] y_coord;
    logic       cfg_valid, cfg_enable_image, cfg_enable_text;
    logic       txt_we;
    logic [6:0] txt_waddr;
    logic [7:0] txt_wdata;
    logic       enable_image, enable_text, frame_start;
    logic [7:0] err_count;
    logic [3:0] fifo_level;

    int checks   = 0;
    int failures = 0;

    always #5 pixel_clk = ~pixel_clk;

    overlay_frame_scheduler_if #(.ADDR_W(7)) bus ();

    overlay_frame_scheduler dut (
        .pixel_clk        (pixel_clk),
        .rst              (rst),
        .y_coord          (y_coord),
        .req              (bus.slave),
        .cfg_valid        (cfg_valid),
        .cfg_enable_image (cfg_enable_image),
        .cfg_enable_text  (cfg_enable_text),
        .txt_we           (txt_we),
        .txt_waddr        (txt_waddr),
        .txt_wdata        (txt_wdata),
        .enable_image     (enable_image),
        .enable_text      (enable_text),
        .frame_start      (frame_start),
        .err_count        (err_count),
        .fifo_level       (fifo_level)
    );

    task automatic step;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        cfg_valid   = 1'b0;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        int bad;
        rst = 1'b1;
        y_coord = 10'd0;
        cfg_valid = 1'b0; cfg_enable_image = 1'b0; cfg_enable_text = 1'b0;
        bus.a_valid = 1'b1; bus.a_addr = 7'd1; bus.a_char = 8'h41;
        bus.b_valid = 1'b1; bus.b_addr = 7'd2; bus.b_char = 8'h42;
        step;
        step;
        checks++;
        if ({txt_we, txt_waddr, txt_wdata, enable_image, enable_text, frame_start,
             err_count, fifo_level, bus.a_ready, bus.b_ready} !== 40'd0) begin
            failures++;
            $display("FAIL reset_outputs: we=%b wa=%0d wd=%h img=%b txt=%b fs=%b err=%0d lvl=%0d ar=%b br=%b, all must be 0",
                     txt_we, txt_waddr, txt_wdata, enable_image, enable_text, frame_start,
                     err_count, fifo_level, bus.a_ready, bus.b_ready);
        end
        rst = 1'b0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 720; i++) begin
            y_coord = 10'(i);
            step;
            if (txt_we || frame_start || enable_image || enable_text || fifo_level != 0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL active_quiet: %0d active-region cycles with activity, want 0", bad);
        end
        y_coord = 10'd720;
        step;
        checks++;
        if (frame_start !== 1'b1) begin
            failures++;
            $display("FAIL frame_start_pulse: got %b want 1", frame_start);
        end
        step;
        checks++;
        if (frame_start !== 1'b0) begin
            failures++;
            $display("FAIL frame_start_single: got %b want 0", frame_start);
        end
    endtask

    task automatic test_single_write;
        int cnt;
        y_coord = 10'd100;
        step;
        bus.a_valid = 1'b1; bus.a_addr = 7'd3; bus.a_char = 8'h48;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready: got %b want 1", bus.a_ready);
        end
        step;
        bus.a_valid = 1'b0;
        checks++;
        if (fifo_level !== 4'd1 || txt_we !== 1'b0) begin
            failures++;
            $display("FAIL single_queued: lvl=%0d we=%b want lvl=1 we=0", fifo_level, txt_we);
        end
        y_coord = 10'd720;
        step;
        step;
        checks++;
        if (txt_we !== 1'b1 || txt_waddr !== 7'd3 || txt_wdata !== 8'h48 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL single_commit: we=%b wa=%0d wd=%h lvl=%0d want 1/3/48/0",
                     txt_we, txt_waddr, txt_wdata, fifo_level);
        end
        cnt = 0;
        repeat (5) begin
            step;
            if (txt_we) cnt++;
        end
        checks++;
        if (cnt !== 0) begin
            failures++;
            $display("FAIL single_once: %0d extra writes, want 0", cnt);
        end
    endtask

    task automatic test_round_robin;
        int ai, bi;
        logic [1:0] exp_rdy;
        logic [6:0] exp_addr;
        logic [7:0] exp_char;
        do_reset;
        y_coord = 10'd100;
        step;
        ai = 0; bi = 0;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.a_addr = 7'(10 + ai); bus.a_char = 8'(8'h61 + ai);
            bus.b_addr = 7'(20 + bi); bus.b_char = 8'(8'h41 + bi);
            #1;
            exp_rdy = (k % 2 == 0) ? 2'b10 : 2'b01;
            checks++;
            if ({bus.a_ready, bus.b_ready} !== exp_rdy) begin
                failures++;
                $display("FAIL rr_grant k=%0d: got %b want %b", k, {bus.a_ready, bus.b_ready}, exp_rdy);
            end
            if (bus.a_ready) ai++;
            else if (bus.b_ready) bi++;
            step;
        end
        #1;
        checks++;
        if ({bus.a_ready, bus.b_ready} !== 2'b00 || fifo_level !== 4'd8) begin
            failures++;
            $display("FAIL rr_full: rdy=%b lvl=%0d want 00/8", {bus.a_ready, bus.b_ready}, fifo_level);
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        y_coord = 10'd720;
        step;
        step;
        for (int k = 0; k < 8; k++) begin
            exp_addr = (k % 2 == 0) ? 7'(10 + k / 2) : 7'(20 + k / 2);
            exp_char = (k % 2 == 0) ? 8'(8'h61 + k / 2) : 8'(8'h41 + k / 2);
            checks++;
            if (txt_we !== 1'b1 || txt_waddr !== exp_addr || txt_wdata !== exp_char) begin
                failures++;
                $display("FAIL rr_order k=%0d: we=%b wa=%0d wd=%h want 1/%0d/%h",
                         k, txt_we, txt_waddr, txt_wdata, exp_addr, exp_char);
            end
            step;
        end
        checks++;
        if (txt_we !== 1'b0 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL rr_done: we=%b lvl=%0d want 0/0", txt_we, fifo_level);
        end
    endtask

    task automatic test_full_and_partial;
        int cnt;
        do_reset;
        y_coord = 10'd100;
        step;
        bus.a_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.a_addr = 7'(30 + i); bus.a_char = 8'(8'h30 + i);
            step;
        end
        bus.a_addr = 7'd40; bus.a_char = 8'h5A;
        #1;
        checks++;
        if (bus.a_ready !== 1'b0 || fifo_level !== 4'd8) begin
            failures++;
            $display("FAIL full_stall: rdy=%b lvl=%0d want 0/8", bus.a_ready, fifo_level);
        end
        y_coord = 10'd720;
        step;
        checks++;
        if (bus.a_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_cycle_ready: got %b want 0", bus.a_ready);
        end
        step;
        checks++;
        if (bus.a_ready !== 1'b1 || fifo_level !== 4'd7 || txt_we !== 1'b1 || txt_waddr !== 7'd30) begin
            failures++;
            $display("FAIL full_reopen: rdy=%b lvl=%0d we=%b wa=%0d want 1/7/1/30",
                     bus.a_ready, fifo_level, txt_we, txt_waddr);
        end
        bus.a_valid = 1'b0;
        step;
        step;
        y_coord = 10'd0;
        step;
        checks++;
        if (txt_we !== 1'b0 || fifo_level !== 4'd5) begin
            failures++;
            $display("FAIL partial_stop: we=%b lvl=%0d want 0/5", txt_we, fifo_level);
        end
        cnt = 0;
        repeat (4) begin
            step;
            if (txt_we) cnt++;
        end
        checks++;
        if (cnt !== 0) begin
            failures++;
            $display("FAIL no_pop_active: %0d writes outside blanking, want 0", cnt);
        end
        y_coord = 10'd720;
        step;
        for (int k = 0; k < 5; k++) begin
            step;
            checks++;
            if (txt_we !== 1'b1 || txt_waddr !== 7'(33 + k) || txt_wdata !== 8'(8'h33 + k)) begin
                failures++;
                $display("FAIL partial_resume k=%0d: we=%b wa=%0d wd=%h want 1/%0d/%h",
                         k, txt_we, txt_waddr, txt_wdata, 33 + k, 8'h33 + k);
            end
        end
        step;
        checks++;
        if (txt_we !== 1'b0 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL partial_done: we=%b lvl=%0d want 0/0", txt_we, fifo_level);
        end
    endtask

    task automatic test_errors_and_sanitise;
        do_reset;
        y_coord = 10'd100;
        step;
        bus.a_valid = 1'b1; bus.a_addr = 7'd80; bus.a_char = 8'h78;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1) begin
            failures++;
            $display("FAIL err_ready: got %b want 1", bus.a_ready);
        end
        step;
        bus.a_valid = 1'b0;
        checks++;
        if (err_count !== 8'd1 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL err_drop: err=%0d lvl=%0d want 1/0", err_count, fifo_level);
        end
        bus.a_valid = 1'b1; bus.a_addr = 7'd5; bus.a_char = 8'hC1;
        step;
        bus.a_valid = 1'b0;
        y_coord = 10'd720;
        step;
        step;
        checks++;
        if (txt_we !== 1'b1 || txt_waddr !== 7'd5 || txt_wdata !== 8'h3F) begin
            failures++;
            $display("FAIL sanitise: we=%b wa=%0d wd=%h want 1/5/3f", txt_we, txt_waddr, txt_wdata);
        end
        y_coord = 10'd100;
        step;
        bus.b_valid = 1'b1; bus.b_addr = 7'd127; bus.b_char = 8'h00;
        repeat (199) step;
        checks++;
        if (err_count !== 8'd200) begin
            failures++;
            $display("FAIL err_count_mid: got %0d want 200", err_count);
        end
        repeat (101) step;
        bus.b_valid = 1'b0;
        checks++;
        if (err_count !== 8'd255 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL err_saturate: err=%0d lvl=%0d want 255/0", err_count, fifo_level);
        end
    endtask

    task automatic test_config;
        do_reset;
        y_coord = 10'd100;
        step;
        y_coord = 10'd200;
        cfg_valid = 1'b1; cfg_enable_image = 1'b1; cfg_enable_text = 1'b0;
        step;
        cfg_valid = 1'b0;
        repeat (3) step;
        checks++;
        if ({enable_image, enable_text} !== 2'b00) begin
            failures++;
            $display("FAIL cfg_hold: got %b want 00", {enable_image, enable_text});
        end
        y_coord = 10'd720;
        step;
        checks++;
        if ({frame_start, enable_image, enable_text} !== 3'b110) begin
            failures++;
            $display("FAIL cfg_apply: fs/img/txt=%b want 110", {frame_start, enable_image, enable_text});
        end
        y_coord = 10'd100;
        step;
        y_coord = 10'd720;
        cfg_valid = 1'b1; cfg_enable_image = 1'b0; cfg_enable_text = 1'b1;
        step;
        cfg_valid = 1'b0;
        checks++;
        if ({frame_start, enable_image, enable_text} !== 3'b110) begin
            failures++;
            $display("FAIL cfg_coincident: fs/img/txt=%b want 110", {frame_start, enable_image, enable_text});
        end
        y_coord = 10'd100;
        step;
        y_coord = 10'd720;
        step;
        checks++;
        if ({enable_image, enable_text} !== 2'b01) begin
            failures++;
            $display("FAIL cfg_next_frame: got %b want 01", {enable_image, enable_text});
        end
        y_coord = 10'd100;
        step;
        cfg_valid = 1'b1; cfg_enable_image = 1'b1; cfg_enable_text = 1'b1;
        step;
        cfg_enable_image = 1'b1; cfg_enable_text = 1'b0;
        step;
        cfg_valid = 1'b0;
        checks++;
        if ({enable_image, enable_text} !== 2'b01) begin
            failures++;
            $display("FAIL cfg_midframe: got %b want 01", {enable_image, enable_text});
        end
        y_coord = 10'd720;
        step;
        checks++;
        if ({enable_image, enable_text} !== 2'b10) begin
            failures++;
            $display("FAIL cfg_last_wins: got %b want 10", {enable_image, enable_text});
        end
    endtask

    task automatic test_reset_mid_drain;
        int cnt;
        do_reset;
        y_coord = 10'd100;
        step;
        bus.a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.a_addr = 7'(50 + i); bus.a_char = 8'(8'h50 + i);
            step;
        end
        bus.a_valid = 1'b0;
        checks++;
        if (fifo_level !== 4'd4) begin
            failures++;
            $display("FAIL rstdrain_fill: lvl=%0d want 4", fifo_level);
        end
        y_coord = 10'd720;
        step;
        step;
        checks++;
        if (txt_we !== 1'b1 || txt_waddr !== 7'd50) begin
            failures++;
            $display("FAIL rstdrain_first: we=%b wa=%0d want 1/50", txt_we, txt_waddr);
        end
        rst = 1'b1;
        step;
        checks++;
        if (txt_we !== 1'b0 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL rstdrain_clear: we=%b lvl=%0d want 0/0", txt_we, fifo_level);
        end
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            step;
            if (txt_we) cnt++;
        end
        checks++;
        if (cnt !== 0 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL rstdrain_after: writes=%0d lvl=%0d want 0/0", cnt, fifo_level);
        end
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_round_robin;
        test_full_and_partial;
        test_errors_and_sanitise;
        test_config;
        test_reset_mid_drain;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
